// File: rtl/PKG_pwm.sv
// Shared definitions for the PWM clock divider family.
//   _pwm_onoff         : per-channel enable encoding (PWM_OFF / PWM_ON)
//   PWM_DIV_W_DEFAULT  : default divider / counter width
//   PWM_N_CH_DEFAULT   : default number of divider channels
package PKG_pwm;

  typedef enum logic {
    PWM_OFF = 1'b0,
    PWM_ON  = 1'b1
  } _pwm_onoff;

  localparam int PWM_DIV_W_DEFAULT = 8;
  localparam int PWM_N_CH_DEFAULT  = 4;

endpackage

// File: rtl/div_pwm_clock_ch.sv
// One PWM divider channel: 50%-duty toggle clock with a shadowed divider
// that only takes effect at a toggle boundary or a phase restart.
// Ports:
//   clk, reset   fabric clock, asynchronous active-high reset
//   divider      divider value presented for capture
//   div_load     strobe: capture divider into the shadow register
//   pwm_onoff    PWM_ON runs the channel, PWM_OFF holds it cleared
//   sync         strobe: restart the phase (ignored while OFF)
//   pwm_clk      divided clock, half-period = active divider + 1 cycles
//   rise_tick    one-cycle pulse on the same edge pwm_clk goes 0->1
//   div_pending  shadow holds a value not yet applied
module div_pwm_clock_ch
  import PKG_pwm::*;
#(
  parameter int DIV_W = PWM_DIV_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] divider,
  input  logic             div_load,
  input  logic             pwm_onoff,
  input  logic             sync,
  output logic             pwm_clk,
  output logic             rise_tick,
  output logic             div_pending
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] act_q, act_d;
  logic [DIV_W-1:0] shad_q, shad_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             pend_q, pend_d;
  logic             ch_on;

  assign ch_on = (pwm_onoff == PWM_ON);

  always_comb begin
    cnt_d  = cnt_q;
    act_d  = act_q;
    shad_d = shad_q;
    clk_d  = clk_q;
    tick_d = 1'b0;
    pend_d = pend_q;

    if (!ch_on || sync) begin
      // Held off or phase restart: the shadow is adopted so a restart
      // always begins with the most recently loaded divider.
      cnt_d  = '0;
      clk_d  = 1'b0;
      act_d  = shad_q;
      pend_d = 1'b0;
    end else if (cnt_q >= act_q) begin
      // ">=" rather than "==" so a counter that is somehow above the
      // divider terminates immediately instead of wrapping.
      cnt_d  = '0;
      clk_d  = ~clk_q;
      tick_d = ~clk_q;
      act_d  = shad_q;
      pend_d = 1'b0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // A load on the applying edge wins over the clear: the old shadow was
    // just applied above and the new value stays pending.
    if (div_load) begin
      shad_d = divider;
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      act_q  <= '0;
      shad_q <= '0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      shad_q <= shad_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
      pend_q <= pend_d;
    end
  end

  assign pwm_clk     = clk_q;
  assign rise_tick   = tick_q;
  assign div_pending = pend_q;

endmodule

// File: rtl/div_pwm_clock_mc.sv
// Multi-channel PWM clock divider. Each channel is an independent
// div_pwm_clock_ch; only the sync strobe is shared between channels.
// Ports:
//   clk, reset   fabric clock, asynchronous active-high reset
//   divider      packed dividers, channel i = divider[i*DIV_W +: DIV_W]
//   div_load     per-channel shadow capture strobe
//   pwm_onoff    per-channel enable (PWM_ON / PWM_OFF)
//   sync         global phase restart strobe for all running channels
//   pwm_clk      per-channel divided clock
//   rise_tick    per-channel rising-edge pulse
//   div_pending  per-channel shadow-not-yet-applied flag
module div_pwm_clock_mc
  import PKG_pwm::*;
#(
  parameter int N_CH  = PWM_N_CH_DEFAULT,
  parameter int DIV_W = PWM_DIV_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH*DIV_W-1:0] divider,
  input  logic [N_CH-1:0]       div_load,
  input  logic [N_CH-1:0]       pwm_onoff,
  input  logic                  sync,
  output logic [N_CH-1:0]       pwm_clk,
  output logic [N_CH-1:0]       rise_tick,
  output logic [N_CH-1:0]       div_pending
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    div_pwm_clock_ch #(
      .DIV_W(DIV_W)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .divider    (divider[g*DIV_W +: DIV_W]),
      .div_load   (div_load[g]),
      .pwm_onoff  (pwm_onoff[g]),
      .sync       (sync),
      .pwm_clk    (pwm_clk[g]),
      .rise_tick  (rise_tick[g]),
      .div_pending(div_pending[g])
    );
  end

endmodule
